// File: rtl/parametrik_medyan_birimi_pkg.sv
// Shared constants and types for the rank-order filter: mode encodings,
// default sample width and the two-state collection/result FSM.
package parametrik_medyan_birimi_pkg;

  localparam int VARSAYILAN_PIXEL_BIT = 8;

  localparam logic [1:0] MOD_MEDYAN = 2'd0;
  localparam logic [1:0] MOD_MIN    = 2'd1;
  localparam logic [1:0] MOD_MAKS   = 2'd2;

  typedef enum logic {
    TOPLA = 1'b0,
    SONUC = 1'b1
  } durum_t;

endpackage

// File: rtl/parametrik_medyan_birimi_siralama_hucresi.sv
// One slot of the insertion-sorted array: keeps its value, inserts the new
// sample, or takes the lower neighbour's value. Purely combinational.
module siralama_hucresi #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_yeni,
  input  logic [W-1:0] i_kendi,
  input  logic [W-1:0] i_alt,
  input  logic         i_dolu,
  input  logic         i_alt_kucuk_esit,
  output logic         o_kucuk_esit,
  output logic [W-1:0] o_sonraki
);

  // Equal entries count as "below" so ties stay in arrival order.
  assign o_kucuk_esit = i_dolu && (i_kendi <= i_yeni);

  assign o_sonraki = o_kucuk_esit     ? i_kendi :
                     i_alt_kucuk_esit ? i_yeni  :
                                        i_alt;

endmodule

// File: rtl/parametrik_medyan_birimi.sv
// Streaming rank-order filter: insertion-sorts PENCERE samples, one per cycle,
// and returns median/min/max one cycle after the last accept; holds until taken.
module parametrik_medyan_birimi
  import parametrik_medyan_birimi_pkg::*;
#(
  parameter int PIXEL_BIT = VARSAYILAN_PIXEL_BIT,
  parameter int PENCERE   = 9
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         giris_gecerli_i,
  output logic                         giris_hazir_o,
  input  logic [PIXEL_BIT-1:0]         sayi_i,
  input  logic [1:0]                   mod_i,
  input  logic                         temizle_i,
  output logic                         cikis_gecerli_o,
  input  logic                         cikis_hazir_i,
  output logic [PIXEL_BIT-1:0]         sonuc_o,
  output logic [$clog2(PENCERE+1)-1:0] doluluk_o
);

  localparam int DW = $clog2(PENCERE+1);

  logic [PIXEL_BIT-1:0] r_dizi      [PENCERE];
  logic [PIXEL_BIT-1:0] w_dizi_next [PENCERE];
  logic [PENCERE-1:0]   w_kucuk_esit;
  logic [DW-1:0]        r_doluluk;
  logic [1:0]           r_mod;
  logic [PIXEL_BIT-1:0] r_sonuc;
  logic [PIXEL_BIT-1:0] w_secim;
  durum_t               r_durum;
  durum_t               w_durum_next;
  logic                 w_kabul;
  logic                 w_yaz;
  logic                 w_son;

  genvar j;
  generate
    for (j = 0; j < PENCERE; j++) begin : g_hucre
      logic [PIXEL_BIT-1:0] w_alt;
      logic                 w_alt_ke;
      if (j == 0) begin : g_ilk
        assign w_alt    = '0;
        assign w_alt_ke = 1'b1;
      end else begin : g_diger
        assign w_alt    = r_dizi[j-1];
        assign w_alt_ke = w_kucuk_esit[j-1];
      end
      siralama_hucresi #(.W(PIXEL_BIT)) u_hucre (
        .i_yeni           (sayi_i),
        .i_kendi          (r_dizi[j]),
        .i_alt            (w_alt),
        .i_dolu           (DW'(j) < r_doluluk),
        .i_alt_kucuk_esit (w_alt_ke),
        .o_kucuk_esit     (w_kucuk_esit[j]),
        .o_sonraki        (w_dizi_next[j])
      );
    end
  endgenerate

  assign w_kabul = giris_gecerli_i && (r_durum == TOPLA);
  assign w_yaz   = w_kabul && !temizle_i;
  assign w_son   = w_yaz && (r_doluluk == DW'(PENCERE-1));

  always_comb begin
    w_secim = w_dizi_next[PENCERE/2];
    case (r_mod)
      MOD_MIN:  w_secim = w_dizi_next[0];
      MOD_MAKS: w_secim = w_dizi_next[PENCERE-1];
      default:  w_secim = w_dizi_next[PENCERE/2];
    endcase
  end

  always_comb begin
    w_durum_next    = r_durum;
    giris_hazir_o   = 1'b0;
    cikis_gecerli_o = 1'b0;
    case (r_durum)
      TOPLA: begin
        giris_hazir_o = 1'b1;
        if (w_son) w_durum_next = SONUC;
      end
      SONUC: begin
        cikis_gecerli_o = 1'b1;
        if (cikis_hazir_i) w_durum_next = TOPLA;
      end
      default: w_durum_next = TOPLA;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_durum   <= TOPLA;
      r_doluluk <= '0;
      r_mod     <= MOD_MEDYAN;
      r_sonuc   <= '0;
    end else begin
      r_durum <= w_durum_next;
      if (r_durum == TOPLA) begin
        if (temizle_i) begin
          r_doluluk <= '0;
        end else if (w_kabul) begin
          r_doluluk <= r_doluluk + DW'(1);
          if (r_doluluk == '0) r_mod <= mod_i;
          if (w_son) r_sonuc <= w_secim;
        end
      end else if (cikis_hazir_i) begin
        r_doluluk <= '0;
      end
    end
  end

  // Stale contents beyond doluluk are harmless: unfilled slots never compare.
  always_ff @(posedge clk_i) begin
    if (w_yaz) begin
      for (int i = 0; i < PENCERE; i++) r_dizi[i] <= w_dizi_next[i];
    end
  end

  assign sonuc_o   = r_sonuc;
  assign doluluk_o = r_doluluk;

endmodule

// File: tb/tb_parametrik_medyan_birimi.sv
// Directed self-checking bench for the rank-order filter (9x8 and 5x10 instances).
module tb_parametrik_medyan_birimi;

  logic       clk = 1'b0;
  logic       rst, gv, temiz, ch;
  logic [7:0] sayi;
  logic [1:0] mod;
  logic       gh, cg;
  logic [7:0] sonuc;
  logic [3:0] dol;

  logic       b_gv, b_ch, b_temiz;
  logic [9:0] b_sayi;
  logic [1:0] b_mod;
  logic       b_gh, b_cg;
  logic [9:0] b_sonuc;
  logic [2:0] b_dol;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  parametrik_medyan_birimi #(.PIXEL_BIT(8), .PENCERE(9)) dut (
    .clk_i(clk), .rst_i(rst), .giris_gecerli_i(gv), .giris_hazir_o(gh),
    .sayi_i(sayi), .mod_i(mod), .temizle_i(temiz), .cikis_gecerli_o(cg),
    .cikis_hazir_i(ch), .sonuc_o(sonuc), .doluluk_o(dol)
  );

  parametrik_medyan_birimi #(.PIXEL_BIT(10), .PENCERE(5)) dut_b (
    .clk_i(clk), .rst_i(rst), .giris_gecerli_i(b_gv), .giris_hazir_o(b_gh),
    .sayi_i(b_sayi), .mod_i(b_mod), .temizle_i(b_temiz), .cikis_gecerli_o(b_cg),
    .cikis_hazir_i(b_ch), .sonuc_o(b_sonuc), .doluluk_o(b_dol)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic adim();
    @(posedge clk);
    #1;
  endtask

  task automatic pencere(input logic [7:0] v[9], input logic [1:0] m, input logic [1:0] m_ara,
                         input logic [7:0] bek, input string tag);
    for (int i = 0; i < 9; i++) begin
      gv = 1'b1; sayi = v[i]; mod = (i == 0) ? m : m_ara;
      adim();
    end
    gv = 1'b0;
    chk({tag, "_gecerli"}, 32'(cg), 32'd1);
    chk({tag, "_sonuc"}, 32'(sonuc), 32'(bek));
    chk({tag, "_hazir"}, 32'(gh), 32'd0);
    ch = 1'b1;
    adim();
    ch = 1'b0;
    chk({tag, "_bitis_gecerli"}, 32'(cg), 32'd0);
    chk({tag, "_bitis_doluluk"}, 32'(dol), 32'd0);
  endtask

  initial begin
    logic [7:0] w[9];
    rst = 1'b1; gv = 1'b0; temiz = 1'b0; ch = 1'b0; sayi = '0; mod = 2'd0;
    b_gv = 1'b0; b_ch = 1'b0; b_temiz = 1'b0; b_sayi = '0; b_mod = 2'd0;
    adim(); adim();
    rst = 1'b0;
    chk("reset_doluluk", 32'(dol), 32'd0);
    chk("reset_hazir", 32'(gh), 32'd1);
    chk("reset_gecerli", 32'(cg), 32'd0);
    chk("reset_sonuc", 32'(sonuc), 32'd0);

    w = '{8'd5, 8'd1, 8'd9, 8'd3, 8'd7, 8'd2, 8'd8, 8'd4, 8'd6};
    pencere(w, 2'd0, 2'd0, 8'd5, "medyan");
    pencere(w, 2'd1, 2'd2, 8'd1, "min_ara_degisim");
    pencere(w, 2'd2, 2'd1, 8'd9, "maks_ara_degisim");
    pencere(w, 2'd3, 2'd1, 8'd5, "mod3_medyan");

    for (int i = 0; i < 9; i++) w[i] = 8'd200;
    pencere(w, 2'd0, 2'd0, 8'd200, "esit_200");
    for (int i = 0; i < 9; i++) w[i] = (i % 2 == 1) ? 8'd255 : 8'd0;
    pencere(w, 2'd0, 2'd0, 8'd0, "uc_deger_medyan");
    pencere(w, 2'd2, 2'd2, 8'd255, "uc_deger_maks");

    // Result held back while a new sample waits at the input.
    w = '{8'd5, 8'd1, 8'd9, 8'd3, 8'd7, 8'd2, 8'd8, 8'd4, 8'd6};
    mod = 2'd0;
    for (int i = 0; i < 9; i++) begin
      gv = 1'b1; sayi = w[i]; adim();
    end
    sayi = 8'd77;
    for (int i = 0; i < 3; i++) begin
      chk("bekleme_sonuc", 32'(sonuc), 32'd5);
      chk("bekleme_hazir", 32'(gh), 32'd0);
      chk("bekleme_gecerli", 32'(cg), 32'd1);
      chk("bekleme_doluluk", 32'(dol), 32'd9);
      adim();
    end
    ch = 1'b1; adim(); ch = 1'b0;
    chk("birakma_gecerli", 32'(cg), 32'd0);
    chk("birakma_doluluk", 32'(dol), 32'd0);
    adim();
    chk("yeni_pencere_ilk", 32'(dol), 32'd1);
    w = '{8'd77, 8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
    for (int i = 1; i < 9; i++) begin
      sayi = w[i]; adim();
    end
    gv = 1'b0;
    chk("yeni_pencere_sonuc", 32'(sonuc), 32'd50);
    chk("yeni_pencere_gecerli", 32'(cg), 32'd1);
    ch = 1'b1; adim(); ch = 1'b0;

    // Flush together with a valid sample: the sample is dropped.
    for (int i = 0; i < 4; i++) begin
      gv = 1'b1; sayi = 8'd100 + 8'(i); adim();
    end
    chk("temizle_oncesi", 32'(dol), 32'd4);
    temiz = 1'b1; sayi = 8'd3; adim(); temiz = 1'b0; gv = 1'b0;
    chk("temizle_sonrasi", 32'(dol), 32'd0);
    w = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    pencere(w, 2'd0, 2'd0, 8'd5, "temizle_pencere");

    // Flush while a result is pending must not disturb it.
    w = '{8'd5, 8'd1, 8'd9, 8'd3, 8'd7, 8'd2, 8'd8, 8'd4, 8'd6};
    for (int i = 0; i < 9; i++) begin
      gv = 1'b1; sayi = w[i]; mod = 2'd2; adim();
    end
    gv = 1'b0; temiz = 1'b1; adim(); temiz = 1'b0;
    chk("sonuc_temizle_gecerli", 32'(cg), 32'd1);
    chk("sonuc_temizle_sonuc", 32'(sonuc), 32'd9);

    // Reset with a result pending.
    rst = 1'b1; adim(); rst = 1'b0;
    chk("rst_sonuc_gecerli", 32'(cg), 32'd0);
    chk("rst_sonuc_sonuc", 32'(sonuc), 32'd0);
    chk("rst_sonuc_hazir", 32'(gh), 32'd1);
    chk("rst_sonuc_doluluk", 32'(dol), 32'd0);

    // Reset mid-window.
    for (int i = 0; i < 3; i++) begin
      gv = 1'b1; sayi = 8'd40; adim();
    end
    chk("rst_ara_oncesi", 32'(dol), 32'd3);
    gv = 1'b0; rst = 1'b1; adim(); rst = 1'b0;
    chk("rst_ara_doluluk", 32'(dol), 32'd0);
    chk("rst_ara_hazir", 32'(gh), 32'd1);
    chk("rst_ara_gecerli", 32'(cg), 32'd0);

    // 5-entry, 10-bit instance.
    b_mod = 2'd0;
    b_gv = 1'b1; b_sayi = 10'd1000; adim();
    b_sayi = 10'd40;   adim();
    b_sayi = 10'd20;   adim();
    b_sayi = 10'd1023; adim();
    chk("b_doluluk_4", 32'(b_dol), 32'd4);
    b_sayi = 10'd30;   adim();
    b_gv = 1'b0;
    chk("b_gecerli", 32'(b_cg), 32'd1);
    chk("b_medyan", 32'(b_sonuc), 32'd40);
    chk("b_hazir", 32'(b_gh), 32'd0);
    b_ch = 1'b1; adim(); b_ch = 1'b0;
    chk("b_bitis", 32'(b_cg), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
